// File: rtl/charmap_video.sv
// Scrolling 8x8 character-map video generator: tile lookup, glyph fetch and colour
// expansion in a three-tick pixel pipeline, with vblank-synchronised scroll registers.
module charmap_video #(
  parameter int MAP_COLS_LOG2 = 6,
  parameter int MAP_ROWS_LOG2 = 5
) (
  input  logic                                   clk_sys,
  input  logic                                   reset,
  input  logic                                   ce_pix,
  input  logic [8:0]                             hcnt,
  input  logic [8:0]                             vcnt,
  input  logic                                   hblank,
  input  logic                                   vblank,
  input  logic                                   reg_wr,
  input  logic [1:0]                             reg_addr,
  input  logic [7:0]                             reg_data,
  output logic [MAP_ROWS_LOG2+MAP_COLS_LOG2-1:0] map_addr,
  input  logic [7:0]                             chram_data,
  input  logic [7:0]                             colram_data,
  output logic [10:0]                            chrom_addr,
  input  logic [7:0]                             chrom_data,
  output logic [7:0]                             VGA_R,
  output logic [7:0]                             VGA_G,
  output logic [7:0]                             VGA_B,
  output logic                                   VGA_HB,
  output logic                                   VGA_VB,
  output logic [7:0]                             frame_cnt
);
  localparam int X_W = MAP_COLS_LOG2 + 3;
  localparam int Y_W = MAP_ROWS_LOG2 + 3;
  localparam int A_W = MAP_ROWS_LOG2 + MAP_COLS_LOG2;

  logic [7:0]     scrollXSh_q, scrollYSh_q, scrollXSh_d, scrollYSh_d;
  logic [X_W-1:0] scrollX_q;
  logic [Y_W-1:0] scrollY_q;
  logic [7:0]     bg_q, frameCnt_q;
  logic [2:0]     ctrl_q;
  logic           vbPrev_q, copyPend_q, immPend_q, vbRise;

  logic [A_W-1:0] mapAddr_q;
  logic [2:0]     fineX1_q, fineY1_q, fineX2_q;
  logic           hb1_q, vb1_q, hb2_q, vb2_q;
  logic [10:0]    chromAddr_q;
  logic [7:0]     colour2_q;
  logic [23:0]    rgb_q, rgb_d;
  logic           hb3_q, vb3_q;
  logic [X_W-1:0] px;
  logic [Y_W-1:0] py;
  logic           pixel;
  logic [7:0]     colour;

  function automatic logic [23:0] expand(input logic [7:0] c);
    return {c[2:0], c[2:0], 2'b00, c[5:3], c[5:3], 2'b00, c[7:6], c[7:6], c[7:6], 2'b00};
  endfunction

  // Shadow next-state includes a same-cycle write, so a copy always sees the newest value.
  always_comb begin
    scrollXSh_d = scrollXSh_q;
    scrollYSh_d = scrollYSh_q;
    if (reg_wr && reg_addr == 2'd0) scrollXSh_d = reg_data;
    if (reg_wr && reg_addr == 2'd1) scrollYSh_d = reg_data;
  end

  assign vbRise = ce_pix && vblank && !vbPrev_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      scrollXSh_q <= '0;
      scrollYSh_q <= '0;
      scrollX_q   <= '0;
      scrollY_q   <= '0;
      bg_q        <= '0;
      ctrl_q      <= '0;
      frameCnt_q  <= '0;
      vbPrev_q    <= 1'b1;
      copyPend_q  <= 1'b0;
      immPend_q   <= 1'b0;
    end else begin
      scrollXSh_q <= scrollXSh_d;
      scrollYSh_q <= scrollYSh_d;
      if (reg_wr && reg_addr == 2'd2) bg_q <= reg_data;
      if (reg_wr && reg_addr == 2'd3) ctrl_q <= reg_data[2:0];
      if (ce_pix) vbPrev_q <= vblank;
      if (vbRise) frameCnt_q <= frameCnt_q + 8'd1;
      copyPend_q <= vbRise;
      immPend_q  <= reg_wr && !reg_addr[1];
      if (copyPend_q || (immPend_q && ctrl_q[2])) begin
        scrollX_q <= X_W'(scrollXSh_d);
        scrollY_q <= Y_W'(scrollYSh_d);
      end
    end
  end

  assign px = X_W'(hcnt) + scrollX_q;
  assign py = Y_W'(vcnt) + scrollY_q;

  // Inverting the glyph bit before the enable gate keeps a disabled display at pure background.
  always_comb begin
    pixel  = chrom_data[3'd7 - fineX2_q] ^ ctrl_q[1];
    colour = (ctrl_q[0] && pixel) ? colour2_q : bg_q;
    rgb_d  = (hb2_q || vb2_q) ? 24'd0 : expand(colour);
  end

  // Blanking stages reset high so pixels in flight at reset never reach the outputs.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mapAddr_q   <= '0;
      fineX1_q    <= '0;
      fineY1_q    <= '0;
      hb1_q       <= 1'b1;
      vb1_q       <= 1'b1;
      chromAddr_q <= '0;
      colour2_q   <= '0;
      fineX2_q    <= '0;
      hb2_q       <= 1'b1;
      vb2_q       <= 1'b1;
      rgb_q       <= '0;
      hb3_q       <= 1'b1;
      vb3_q       <= 1'b1;
    end else if (ce_pix) begin
      mapAddr_q   <= {py[Y_W-1:3], px[X_W-1:3]};
      fineX1_q    <= px[2:0];
      fineY1_q    <= py[2:0];
      hb1_q       <= hblank;
      vb1_q       <= vblank;
      chromAddr_q <= {chram_data, fineY1_q};
      colour2_q   <= colram_data;
      fineX2_q    <= fineX1_q;
      hb2_q       <= hb1_q;
      vb2_q       <= vb1_q;
      rgb_q       <= rgb_d;
      hb3_q       <= hb2_q;
      vb3_q       <= vb2_q;
    end
  end

  assign map_addr   = mapAddr_q;
  assign chrom_addr = chromAddr_q;
  assign VGA_R      = rgb_q[23:16];
  assign VGA_G      = rgb_q[15:8];
  assign VGA_B      = rgb_q[7:0];
  assign VGA_HB     = hb3_q;
  assign VGA_VB     = vb3_q;
  assign frame_cnt  = frameCnt_q;

endmodule

// File: tb/tb_charmap_video.sv
// Self-checking bench for charmap_video: a pixel-level reference model plus directed
// scenarios for colour expansion, scroll latching, wrap, inversion, freeze, frame count and reset.
module tb_charmap_video;
  logic        clk_sys = 1'b0;
  logic        reset, ce_pix, hblank, vblank, reg_wr;
  logic [8:0]  hcnt, vcnt;
  logic [1:0]  reg_addr;
  logic [7:0]  reg_data, chram_data, colram_data, chrom_data;
  logic [10:0] map_addr, chrom_addr;
  logic [7:0]  VGA_R, VGA_G, VGA_B, frame_cnt;
  logic        VGA_HB, VGA_VB;

  charmap_video dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .hcnt(hcnt), .vcnt(vcnt),
    .hblank(hblank), .vblank(vblank), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_data(reg_data), .map_addr(map_addr), .chram_data(chram_data),
    .colram_data(colram_data), .chrom_addr(chrom_addr), .chrom_data(chrom_data),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HB(VGA_HB), .VGA_VB(VGA_VB),
    .frame_cnt(frame_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  logic [7:0] chram [2048];
  logic [7:0] colram[2048];
  logic [7:0] chrom [2048];

  // External memories behave as single-cycle synchronous ROM/RAM.
  always @(posedge clk_sys) begin
    chram_data  <= chram[map_addr];
    colram_data <= colram[map_addr];
    chrom_data  <= chrom[chrom_addr];
  end

  typedef struct { int px; int py; bit hb; bit vb; } pix_t;
  pix_t hist[$];

  int         nChecks = 0;
  int         nFail = 0;
  int         mShX, mShY, mActX, mActY, mFrames;
  logic [7:0] mBg, mCtrl;
  bit         mPrevVb;

  function automatic int mapIdx(input pix_t e);
    return ((e.py / 8) % 32) * 64 + (e.px / 8) % 64;
  endfunction

  // Reference pixel colour from scrolled coordinates, RAM contents and current control state.
  function automatic logic [23:0] expectRgb(input pix_t e);
    int idx, bits, pix, c;
    if (e.hb || e.vb) return 24'd0;
    idx  = mapIdx(e);
    bits = int'(chrom[int'(chram[idx]) * 8 + e.py % 8]);
    pix  = (bits >> (7 - e.px % 8)) & 1;
    if (mCtrl[1]) pix = 1 - pix;
    c = (mCtrl[0] && pix == 1) ? int'(colram[idx]) : int'(mBg);
    return {8'((c % 8) * 36), 8'(((c / 8) % 8) * 36), 8'((c / 64) * 84)};
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    hist.delete();
    mShX = 0; mShY = 0; mActX = 0; mActY = 0; mFrames = 0;
    mBg = 8'h00; mCtrl = 8'h00; mPrevVb = 1'b0;
  endtask

  // One pixel tick: inputs valid for one ce_pix edge, then three idle cycles for the RAMs.
  task automatic applyStimulus(input int h, input int v, input bit hb, input bit vb);
    pix_t e;
    @(negedge clk_sys);
    hcnt = 9'(h); vcnt = 9'(v); hblank = hb; vblank = vb; ce_pix = 1'b1;
    e.px = (h + mActX) % 512;
    e.py = (v + mActY) % 256;
    e.hb = hb; e.vb = vb;
    hist.push_back(e);
    if (vb && !mPrevVb) begin
      mFrames = (mFrames + 1) % 256;
      mActX = mShX; mActY = mShY;
    end
    mPrevVb = vb;
    @(negedge clk_sys);
    ce_pix = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic regWrite(input int a, input int d);
    @(negedge clk_sys);
    reg_wr = 1'b1; reg_addr = 2'(a); reg_data = 8'(d);
    @(negedge clk_sys);
    reg_wr = 1'b0;
    case (a)
      0: mShX = d;
      1: mShY = d;
      2: mBg = 8'(d);
      default: mCtrl = 8'(d);
    endcase
    if (a < 2 && mCtrl[2]) begin mActX = mShX; mActY = mShY; end
    @(negedge clk_sys);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " VGA_R"}, int'(VGA_R), 0);
    checkOutput({tag, " VGA_G"}, int'(VGA_G), 0);
    checkOutput({tag, " VGA_B"}, int'(VGA_B), 0);
    checkOutput({tag, " VGA_HB"}, int'(VGA_HB), 1);
    checkOutput({tag, " VGA_VB"}, int'(VGA_VB), 1);
    checkOutput({tag, " map_addr"}, int'(map_addr), 0);
    checkOutput({tag, " chrom_addr"}, int'(chrom_addr), 0);
    checkOutput({tag, " frame_cnt"}, int'(frame_cnt), 0);
  endtask

  // Per-tick comparison of every pipeline-visible output against the model.
  always @(posedge clk_sys) begin
    if (ce_pix && !reset) begin
      int n;
      #1;
      n = hist.size();
      if (n >= 1) checkOutput("model map_addr", int'(map_addr), mapIdx(hist[n-1]));
      if (n >= 2) checkOutput("model chrom_addr", int'(chrom_addr),
                              int'(chram[mapIdx(hist[n-2])]) * 8 + hist[n-2].py % 8);
      if (n >= 3) begin
        checkOutput("model rgb", int'({VGA_R, VGA_G, VGA_B}), int'(expectRgb(hist[n-3])));
        checkOutput("model VGA_HB", int'(VGA_HB), int'(hist[n-3].hb));
        checkOutput("model VGA_VB", int'(VGA_VB), int'(hist[n-3].vb));
      end
      checkOutput("model frame_cnt", int'(frame_cnt), mFrames);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] sR, sG, sB;
    logic       sHb, sVb;
    logic [10:0] sMap, sChr;
    reset = 1'b0; ce_pix = 1'b0; hcnt = '0; vcnt = '0; hblank = 1'b0; vblank = 1'b0;
    reg_wr = 1'b0; reg_addr = '0; reg_data = '0;
    for (int i = 0; i < 2048; i++) begin
      chram[i]  = 8'(i * 7 + 3);
      colram[i] = 8'(i * 13 + 5);
      chrom[i]  = 8'(i * 29 + 1);
    end
    chram[0] = 8'h41; colram[0] = 8'h07; chrom[11'h208] = 8'h80;
    modelReset();
    #2 reset = 1'b1;
    #1 checkResetValues("power-on reset");
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;

    // Glyph bit 7 at tile 0 with colour 0x07 gives pure red.
    regWrite(3, 8'h01);
    applyStimulus(0, 0, 0, 0); applyStimulus(8, 0, 0, 0); applyStimulus(16, 0, 0, 0);
    checkOutput("basic VGA_R", int'(VGA_R), 8'hFC);
    checkOutput("basic VGA_G", int'(VGA_G), 0);
    checkOutput("basic VGA_B", int'(VGA_B), 0);

    // Scroll write during active video waits for the vblank rising edge.
    applyStimulus(16, 0, 0, 0);
    checkOutput("scroll before write map_addr", int'(map_addr), 2);
    regWrite(0, 8);
    applyStimulus(16, 0, 0, 0);
    checkOutput("scroll held map_addr", int'(map_addr), 2);
    applyStimulus(0, 200, 0, 1);
    applyStimulus(16, 0, 0, 0);
    checkOutput("scroll applied map_addr", int'(map_addr), 3);

    // Immediate mode, horizontal wrap: 0x102 + 0xFF = 0x001 -> column 0, fine x 1 (bit 6 clear).
    regWrite(3, 8'h05);
    regWrite(2, 8'h3F);
    regWrite(0, 8'hFF);
    applyStimulus(9'h102, 0, 0, 0);
    checkOutput("wrap map_addr", int'(map_addr), 0);
    applyStimulus(9'h10A, 0, 0, 0); applyStimulus(9'h112, 0, 0, 0);
    checkOutput("wrap VGA_R", int'(VGA_R), 8'hFC);
    checkOutput("wrap VGA_G", int'(VGA_G), 8'hFC);
    checkOutput("wrap VGA_B", int'(VGA_B), 0);

    // Inversion turns a set glyph bit into background 0xC0 (blue), then blanking forces black.
    regWrite(0, 0);
    regWrite(3, 8'h03);
    regWrite(2, 8'hC0);
    applyStimulus(0, 0, 0, 0); applyStimulus(8, 0, 0, 0); applyStimulus(16, 0, 0, 0);
    checkOutput("invert VGA_R", int'(VGA_R), 0);
    checkOutput("invert VGA_G", int'(VGA_G), 0);
    checkOutput("invert VGA_B", int'(VGA_B), 8'hFC);
    applyStimulus(0, 0, 1, 0); applyStimulus(8, 0, 0, 0); applyStimulus(16, 0, 0, 0);
    checkOutput("hblank rgb", int'({VGA_R, VGA_G, VGA_B}), 0);
    checkOutput("hblank VGA_HB", int'(VGA_HB), 1);

    // Outputs hold while ce_pix is low.
    applyStimulus(24, 3, 0, 0); applyStimulus(32, 3, 0, 0);
    sR = VGA_R; sG = VGA_G; sB = VGA_B; sHb = VGA_HB; sVb = VGA_VB; sMap = map_addr; sChr = chrom_addr;
    repeat (10) @(negedge clk_sys);
    checkOutput("freeze rgb", int'({VGA_R, VGA_G, VGA_B}), int'({sR, sG, sB}));
    checkOutput("freeze blank", int'({VGA_HB, VGA_VB}), int'({sHb, sVb}));
    checkOutput("freeze map_addr", int'(map_addr), int'(sMap));
    checkOutput("freeze chrom_addr", int'(chrom_addr), int'(sChr));

    // One frame was counted already; 255 more wrap to 0, one more gives 1.
    for (int f = 0; f < 255; f++) begin
      applyStimulus(f, 10, 0, 0);
      applyStimulus(f, 240, 1, 1);
    end
    checkOutput("frame_cnt wrap", int'(frame_cnt), 0);
    applyStimulus(0, 10, 0, 0);
    applyStimulus(0, 240, 0, 1);
    checkOutput("frame_cnt after wrap", int'(frame_cnt), 1);

    // Reset in mid-line clears everything at once; output is valid three ticks after release.
    applyStimulus(40, 5, 0, 0); applyStimulus(48, 5, 0, 0);
    @(negedge clk_sys);
    reset = 1'b1;
    #1 checkResetValues("mid-line reset");
    modelReset();
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    regWrite(3, 8'h01);
    applyStimulus(0, 0, 0, 0); applyStimulus(8, 0, 0, 0); applyStimulus(16, 0, 0, 0);
    checkOutput("post-reset VGA_R", int'(VGA_R), 8'hFC);
    checkOutput("post-reset VGA_HB", int'(VGA_HB), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
